cla_response_checker: RTL and testbench
=======================================

Name: cla_response_checker

Overview:
- Synthesizable response checker on the output side of the CLA adder interface.
- Consumes the stimulus stream driven into the adder (a, b, cin, valid) and the adder's registered outputs (sum, Cout, G, P).
- Builds expected results, delays them by the adder latency, compares each valid beat, and keeps pass/fail counters and a first-failure capture for benches and on-chip self-test.

Parameters:
- WIDTH, 32, operand and sum width.
- LATENCY, 1, adder input-to-output latency in cycles; legal range 1..4.
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of counters, sticky flag and capture.
- in_valid  input  1  stimulus beat presented to the adder this cycle.
- a  input  WIDTH  adder operand A.
- b  input  WIDTH  adder operand B.
- cin  input  1  adder carry-in.
- dut_sum  input  WIDTH  adder sum output.
- dut_cout  input  1  adder carry-out.
- dut_g  input  1  adder group generate.
- dut_p  input  1  adder group propagate.
- chk_valid  output  1  a comparison occurred this cycle.
- mism_mask  output  4  per-field mismatch for the current comparison: [0] sum, [1] cout, [2] g, [3] p.
- chk_count  output  CNT_W  beats compared, saturating.
- err_count  output  CNT_W  beats with any mismatch, saturating.
- err_sticky  output  1  set on the first mismatch; held until clear or reset.
- first_err_exp  output  WIDTH  expected sum of the first failing beat.
- first_err_got  output  WIDTH  DUT sum of the first failing beat.
- first_err_idx  output  CNT_W  chk_count value at the first failing beat.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, pipeline valid bits 0, state IDLE.
- Expected-result model, computed combinationally at the input stage:
  - exp_sum = (a + b + cin) mod 2^WIDTH.
  - exp_p = AND over i of (a[i] | b[i]).
  - exp_g = g[W-1] | p[W-1]g[W-2] | p[W-1]p[W-2]g[W-3] ... , with g = a&b and p = a|b.
  - exp_cout = exp_g | (exp_p & cin). This equals bit WIDTH of a+b+cin.
- Expected pipeline:
  - LATENCY stages, each holding {valid, exp_sum, exp_cout, exp_g, exp_p}.
  - Stage 0 loads in_valid with the expected values every cycle.
  - Bubbles (valid=0) propagate and are never compared.
- Compare, when the last stage's valid is 1:
  - chk_valid=1, registered; it appears 1 cycle after the DUT outputs are sampled, so total latency from in_valid is LATENCY+1.
  - mism_mask is registered alongside chk_valid. It is 0 whenever chk_valid=0.
- Counters:
  - chk_count increments on each compare.
  - err_count increments when mism_mask != 0.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - first_err_idx records chk_count before its increment.
- State machine:
  - IDLE: no comparison yet. Goes to RUN on the first compare, or to FAIL on a first compare that mismatches.
  - RUN: all compares passing. Goes to FAIL on a mismatch.
  - FAIL: err_sticky=1; the first_err_* registers are frozen. Later mismatches only bump err_count.
  - clear from any state returns to IDLE.
- clear:
  - Zeroes the counters, err_sticky and the capture registers.
  - Does not flush the expected pipeline, so beats already in flight are still compared after clear.
  - clear and a compare in the same cycle: clear wins and that compare is discarded.
- Reset mid-stream: in-flight expected beats are dropped. DUT outputs arriving after reset release are ignored until a new in_valid propagates.
- Back-to-back valid every cycle is supported with no stalls. There is no backpressure.

Decomposition:
- Shared package cla_pkg: CLA_WIDTH=32; a check_state_t enum {IDLE, RUN, FAIL}; mism_mask bit-index constants; a packed cla_exp_t struct {sum, cout, g, p}.
- Sub-module cla_ref_model: combinational golden model (a, b, cin -> cla_exp_t). It is reusable by other benches.

Test Plan:
- Stimulus a=FFFFFFFF, b=0, cin=0 valid; DUT returns sum FFFFFFFF, cout 0, g 0, p 1 -> chk_valid pulse, mism_mask=0000, chk_count=1, err_count=0, state RUN.
- Stimulus a=FFFFFFFF, b=0, cin=1; DUT returns sum 00000000, cout 1, g 0, p 1 -> mism_mask=0000. Confirms the cout = G|P·cin path.
- Stimulus a=2, b=3, cin=0; DUT forced sum=4 -> mism_mask=0001, err_count=1, err_sticky=1, first_err_exp=5, first_err_got=4, first_err_idx=0.
- Second fault, DUT cout flipped on a=80000000, b=80000000 -> mism_mask=0010, err_count=2; first_err_* unchanged from the first fault.
- CNT_W=4, 20 consecutive faulty beats -> err_count and chk_count hold at 15.
- rst_n pulsed low while 1 beat is in flight (LATENCY=2) -> outputs 0 immediately, no chk_valid afterwards. clear asserted in the same cycle as a compare -> counters stay 0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types for the CLA adder response checker: checker states,
// mismatch-mask bit positions and the expected-result record.
package cla_pkg;

  localparam int CLA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } check_state_t;

  localparam int MISM_SUM  = 0;
  localparam int MISM_COUT = 1;
  localparam int MISM_G    = 2;
  localparam int MISM_P    = 3;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] sum;
    logic                 cout;
    logic                 g;
    logic                 p;
  } cla_exp_t;

endpackage

// File: rtl/cla_ref_model.sv
// Combinational golden model of the CLA adder: sum, carry-out and the
// group generate/propagate terms for one operand pair.
module cla_ref_model
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             g_o,
  output logic             p_o
);

  logic [WIDTH-1:0] g_bit, p_bit;
  logic             g_acc;

  assign g_bit = a_i & b_i;
  assign p_bit = a_i | b_i;
  assign sum_o = a_i + b_i + {{(WIDTH-1){1'b0}}, cin_i};
  assign p_o   = &p_bit;

  // Ripple the generate term from LSB upward; the MSB term ends up dominant.
  always_comb begin
    g_acc = 1'b0;
    for (int i = 0; i < WIDTH; i++) g_acc = g_bit[i] | (p_bit[i] & g_acc);
  end

  assign g_o    = g_acc;
  assign cout_o = g_acc | (p_o & cin_i);

endmodule

// File: rtl/cla_response_checker.sv
// Response checker for the CLA adder: delays golden results by the adder
// latency, compares each valid beat and tracks counts plus first failure.
module cla_response_checker
  import cla_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  input  logic             dut_g,
  input  logic             dut_p,
  output logic             chk_valid,
  output logic [3:0]       mism_mask,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             g;
    logic             p;
  } exp_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  exp_t                      exp_in;
  exp_t [LATENCY-1:0]        exp_pipe_q;
  logic [LATENCY-1:0]        vld_pipe_q;

  cla_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i    (a),
    .b_i    (b),
    .cin_i  (cin),
    .sum_o  (exp_in.sum),
    .cout_o (exp_in.cout),
    .g_o    (exp_in.g),
    .p_o    (exp_in.p)
  );

  // Expected pipeline always shifts; bubbles ride along and are never compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      exp_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= in_valid;
      exp_pipe_q[0] <= exp_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        exp_pipe_q[i] <= exp_pipe_q[i-1];
      end
    end
  end

  exp_t       exp_last;
  logic       cmp;
  logic [3:0] mism;
  logic       any_mism;

  assign exp_last        = exp_pipe_q[LATENCY-1];
  assign cmp             = vld_pipe_q[LATENCY-1];
  assign mism[MISM_SUM]  = dut_sum  != exp_last.sum;
  assign mism[MISM_COUT] = dut_cout != exp_last.cout;
  assign mism[MISM_G]    = dut_g    != exp_last.g;
  assign mism[MISM_P]    = dut_p    != exp_last.p;
  assign any_mism        = |mism;

  check_state_t     state_q, state_d;
  logic             chk_valid_q, chk_valid_d;
  logic [3:0]       mism_q, mism_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d, err_cnt_q, err_cnt_d, fidx_q, fidx_d;
  logic [WIDTH-1:0] fexp_q, fexp_d, fgot_q, fgot_d;

  always_comb begin
    state_d     = state_q;
    chk_valid_d = 1'b0;
    mism_d      = '0;
    chk_cnt_d   = chk_cnt_q;
    err_cnt_d   = err_cnt_q;
    fidx_d      = fidx_q;
    fexp_d      = fexp_q;
    fgot_d      = fgot_q;
    // clear outranks a same-cycle compare, which is simply dropped.
    if (clear) begin
      state_d   = IDLE;
      chk_cnt_d = '0;
      err_cnt_d = '0;
      fidx_d    = '0;
      fexp_d    = '0;
      fgot_d    = '0;
    end else if (cmp) begin
      chk_valid_d = 1'b1;
      mism_d      = mism;
      if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + 1'b1;
      if (any_mism) begin
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (state_q != FAIL) begin
          state_d = FAIL;
          fidx_d  = chk_cnt_q;
          fexp_d  = exp_last.sum;
          fgot_d  = dut_sum;
        end
      end else if (state_q == IDLE) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chk_valid_q <= 1'b0;
      mism_q      <= '0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      fidx_q      <= '0;
      fexp_q      <= '0;
      fgot_q      <= '0;
    end else begin
      state_q     <= state_d;
      chk_valid_q <= chk_valid_d;
      mism_q      <= mism_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      fidx_q      <= fidx_d;
      fexp_q      <= fexp_d;
      fgot_q      <= fgot_d;
    end
  end

  assign chk_valid     = chk_valid_q;
  assign mism_mask     = mism_q;
  assign chk_count     = chk_cnt_q;
  assign err_count     = err_cnt_q;
  assign err_sticky    = (state_q == FAIL);
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;
  assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_cla_response_checker.sv
// Bench for cla_response_checker: emulates a LATENCY-cycle adder with
// injectable faults and checks every output each cycle against a model.
module tb_cla_response_checker;

  localparam int W    = 32;
  localparam int L    = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, cin = 1'b0;
  logic [W-1:0]  a = '0, b = '0, dut_sum = '0;
  logic          dut_cout = 1'b0, dut_g = 1'b0, dut_p = 1'b0;
  logic          chk_valid, err_sticky;
  logic [3:0]    mism_mask;
  logic [CW-1:0] chk_count, err_count, first_err_idx;
  logic [W-1:0]  first_err_exp, first_err_got;

  cla_response_checker #(.WIDTH(W), .LATENCY(L), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .dut_sum       (dut_sum),
    .dut_cout      (dut_cout),
    .dut_g         (dut_g),
    .dut_p         (dut_p),
    .chk_valid     (chk_valid),
    .mism_mask     (mism_mask),
    .chk_count     (chk_count),
    .err_count     (err_count),
    .err_sticky    (err_sticky),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got),
    .first_err_idx (first_err_idx)
  );

  always #5 clk = ~clk;

  // One beat: operands plus the corruption the emulated adder applies to it.
  typedef struct {
    bit         v;
    bit [W-1:0] a, b;
    bit         cin;
    bit [W-1:0] sx;
    bit [2:0]   fx;
  } beat_t;

  beat_t      inflight[$];
  int         checks = 0, errors = 0;
  bit         m_cv, m_sticky;
  bit [3:0]   m_mm;
  int         m_chk, m_err, m_fidx;
  bit [W-1:0] m_fexp, m_fgot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("chk_valid", 32'(chk_valid), 32'(m_cv));
    check("mism_mask", 32'(mism_mask), 32'(m_mm));
    check("chk_count", 32'(chk_count), m_chk);
    check("err_count", 32'(err_count), m_err);
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("first_err_exp", first_err_exp, m_fexp);
    check("first_err_got", first_err_got, m_fgot);
    check("first_err_idx", 32'(first_err_idx), m_fidx);
  endtask

  task automatic model_zero();
    m_cv = 0; m_mm = 0; m_chk = 0; m_err = 0; m_sticky = 0;
    m_fidx = 0; m_fexp = 0; m_fgot = 0;
  endtask

  // Present beat (v,ia,ib,icin) and the adder's answer for the beat L cycles ago.
  task automatic step(input bit v, input bit [W-1:0] ia, input bit [W-1:0] ib, input bit icin,
                      input bit [W-1:0] sx, input bit [2:0] fx, input bit clr);
    beat_t    nb, ob;
    bit [W:0] t;
    bit [W-1:0] s;
    bit       co, g, p;
    bit [3:0] mm;
    nb = '{v, ia, ib, icin, sx, fx};
    inflight.push_back(nb);
    ob = inflight.pop_front();
    t  = {1'b0, ob.a} + {1'b0, ob.b} + {{W{1'b0}}, ob.cin};
    s  = t[W-1:0];
    co = t[W];
    t  = {1'b0, ob.a} + {1'b0, ob.b};
    g  = t[W];
    p  = &(ob.a | ob.b);
    in_valid = v; a = ia; b = ib; cin = icin; clear = clr;
    dut_sum  = s ^ ob.sx;
    dut_cout = co ^ ob.fx[0];
    dut_g    = g ^ ob.fx[1];
    dut_p    = p ^ ob.fx[2];
    mm = {ob.fx[2], ob.fx[1], ob.fx[0], ob.sx != '0};
    if (clr) model_zero();
    else begin
      m_cv = ob.v;
      m_mm = ob.v ? mm : 4'd0;
      if (ob.v) begin
        if (mm != 0) begin
          if (!m_sticky) begin
            m_sticky = 1; m_fexp = s; m_fgot = s ^ ob.sx; m_fidx = m_chk;
          end
          if (m_err < CMAX) m_err++;
        end
        if (m_chk < CMAX) m_chk++;
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, $urandom, $urandom, 1'($urandom), $urandom, 3'($urandom), 0);
  endtask

  task automatic do_reset();
    in_valid = 0; clear = 0;
    #1 rst_n = 0;
    #1;
    model_zero();
    foreach (inflight[i]) inflight[i].v = 0;
    check_all();
    @(posedge clk);
    inflight.delete(0);
    inflight.push_back('{default: '0});
    #1 rst_n = 1;
    #1 check_all();
  endtask

  function automatic bit [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit          v, c, clr;
    bit [W-1:0]  sx;
    bit [2:0]    fx;
    for (int i = 0; i < L; i++) inflight.push_back('{default: '0});
    model_zero();
    #1 check_all();
    @(posedge clk); #1 rst_n = 1;

    // Clean beats: plain add, then the carry-in-through-propagate path.
    step(1, 32'hFFFF_FFFF, 32'h0, 0, '0, 3'b000, 0);
    step(1, 32'hFFFF_FFFF, 32'h0, 1, '0, 3'b000, 0);
    idle(L);
    check("two_clean_chk", 32'(chk_count), 32'd2);
    check("two_clean_err", 32'(err_count), 32'd0);

    // Sum fault then cout fault; capture must keep the first.
    step(0, '0, '0, 0, '0, 3'b000, 1);
    step(1, 32'd2, 32'd3, 0, 32'd1, 3'b000, 0);
    step(1, 32'h8000_0000, 32'h8000_0000, 0, '0, 3'b001, 0);
    idle(L);
    check("fault_err", 32'(err_count), 32'd2);
    check("fault_exp", first_err_exp, 32'd5);
    check("fault_got", first_err_got, 32'd4);
    check("fault_idx", 32'(first_err_idx), 32'd0);
    check("fault_sticky", 32'(err_sticky), 32'd1);

    // Saturation of both counters.
    step(0, '0, '0, 0, '0, 3'b000, 1);
    for (int i = 0; i < 20; i++) step(1, $urandom, $urandom, 1'($urandom), 32'h8, 3'b111, 0);
    idle(L);
    check("sat_chk", 32'(chk_count), 32'(CMAX));
    check("sat_err", 32'(err_count), 32'(CMAX));

    // clear colliding with a compare discards it.
    step(0, '0, '0, 0, '0, 3'b000, 1);
    step(1, $urandom, $urandom, 0, 32'h1, 3'b000, 0);
    idle(L - 1);
    step(0, '0, '0, 0, '0, 3'b000, 1);
    idle(1);
    check("clr_hit_chk", 32'(chk_count), 32'd0);
    check("clr_hit_err", 32'(err_count), 32'd0);

    // Beat in flight across clear is still compared.
    step(1, $urandom, $urandom, 1, '0, 3'b000, 0);
    step(0, '0, '0, 0, '0, 3'b000, 1);
    idle(L);
    check("clr_flight_chk", 32'(chk_count), 32'd1);

    // Reset with a beat in flight drops it.
    step(1, $urandom, $urandom, 0, 32'h3, 3'b000, 0);
    do_reset();
    idle(L + 2);
    check("rst_drop_chk", 32'(chk_count), 32'd0);

    // Randomised traffic with sparse faults, clears and one reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        step(1, rand_op(), rand_op(), 1'($urandom), '0, 3'b000, 0);
        do_reset();
      end
      v   = $urandom_range(0, 3) != 0;
      c   = 1'($urandom);
      clr = $urandom_range(0, 49) == 0;
      sx  = '0;
      fx  = '0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) sx = 32'd1 << $urandom_range(0, 31);
        else fx = 3'd1 << $urandom_range(0, 2);
      end
      step(v, rand_op(), rand_op(), c, sx, fx, clr);
    end
    idle(L + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
